// File: rtl/field_merge_sched.sv
// Merges varint-encoder and raw-data FIFO heads into one byte stream ordered by field index.
// Optional stall watchdog is enabled with FIELD_MERGE_SCHED_WATCHDOG_EN.
module field_merge_sched #(
  parameter int unsigned IDX_W   = 10,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] field_count,
  input  logic             vl_empty,
  input  logic [79:0]      vl_data,
  input  logic [3:0]       vl_size,
  input  logic [IDX_W-1:0] vl_index,
  output logic             vl_pop,
  input  logic             rd_empty,
  input  logic [31:0]      rd_data,
  input  logic [3:0]       rd_wstrb,
  input  logic [IDX_W-1:0] rd_index,
  input  logic             rd_last,
  output logic             rd_pop,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {StIdle, StPick, StEmitVl, StEmitRd, StErr} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] next_idx_q;
  logic [IDX_W-1:0] count_q;
  logic [3:0]       byte_cnt_q;

  logic       accept;
  logic       pop_pending;
  logic       vl_hit;
  logic       rd_hit;
  logic       vl_size_ok;
  logic       last_field;
  logic       rd_wait;
  logic       rd_load;
  logic       rd_end;
  logic       vl_end;
  logic       field_end;
  logic       to_err;
  logic       wd_fire;
  logic [1:0] rd_first_lane;
  logic [1:0] rd_next_lane;
  logic       rd_has_next;
  logic [7:0] rd_first_byte;
  logic [7:0] rd_next_byte;
  logic [7:0] vl_next_byte;

  always_comb begin
    accept      = out_valid & out_ready;
    // A head being popped this cycle is stale; decisions wait one cycle for the new head.
    pop_pending = vl_pop | rd_pop;
    vl_hit      = !vl_empty && (vl_index == next_idx_q);
    rd_hit      = !rd_empty && (rd_index == next_idx_q);
    vl_size_ok  = (vl_size != 4'd0) && (vl_size <= 4'd10);
    last_field  = (next_idx_q + IDX_W'(1)) == count_q;

    rd_wait = (state_q == StEmitRd) && !out_valid && !rd_pop;
    rd_load = ((state_q == StPick) && !pop_pending && !vl_hit && rd_hit) || (rd_wait && rd_hit);
    rd_end  = (rd_load && (rd_wstrb == 4'b0000)) ||
              ((state_q == StEmitRd) && accept && !rd_has_next);
    vl_end  = (state_q == StEmitVl) && accept && ((byte_cnt_q + 4'd1) == vl_size);
    field_end = vl_end || (rd_end && rd_last);

    to_err = ((state_q == StPick) && !pop_pending &&
              ((vl_hit && !vl_size_ok) || (!vl_hit && !rd_hit && !vl_empty && !rd_empty))) ||
             (rd_wait && !rd_empty && !rd_hit) ||
             wd_fire;
  end

  // Lane search: lowest set strobe, and lowest set strobe above the current lane.
  always_comb begin
    rd_first_lane = 2'd0;
    rd_next_lane  = 2'd0;
    rd_has_next   = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (rd_wstrb[i]) begin
        rd_first_lane = 2'(i);
      end
      if (rd_wstrb[i] && (4'(i) > byte_cnt_q)) begin
        rd_next_lane = 2'(i);
        rd_has_next  = 1'b1;
      end
    end
    rd_first_byte = rd_data[8*rd_first_lane +: 8];
    rd_next_byte  = rd_data[8*rd_next_lane +: 8];
    vl_next_byte  = 8'h00;
    for (int i = 1; i < 10; i++) begin
      if (4'(i) == (byte_cnt_q + 4'd1)) begin
        vl_next_byte = vl_data[8*i +: 8];
      end
    end
  end

`ifdef FIELD_MERGE_SCHED_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wd_cnt_q;
  logic           wd_stall;

  always_comb begin
    wd_stall = ((state_q == StPick) && !vl_hit && !rd_hit) || (out_valid && !out_ready);
    wd_fire  = wd_stall && (wd_cnt_q == WdW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
    end else if (!wd_stall || wd_fire) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + WdW'(1);
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      next_idx_q <= '0;
      count_q    <= '0;
      byte_cnt_q <= '0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      vl_pop     <= 1'b0;
      rd_pop     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      vl_pop <= 1'b0;
      rd_pop <= 1'b0;
      done   <= 1'b0;

      unique case (state_q)
        StIdle, StErr: begin
          busy <= 1'b0;
          if (start) begin
            count_q    <= field_count;
            next_idx_q <= '0;
            byte_cnt_q <= '0;
            err        <= 1'b0;
            if (field_count == '0) begin
              done    <= 1'b1;
              state_q <= StIdle;
            end else begin
              busy    <= 1'b1;
              state_q <= StPick;
            end
          end
        end
        StPick: begin
          if (!pop_pending) begin
            if (vl_hit && vl_size_ok) begin
              out_valid  <= 1'b1;
              out_data   <= vl_data[7:0];
              byte_cnt_q <= '0;
              state_q    <= StEmitVl;
            end else if (!vl_hit && rd_hit) begin
              state_q <= StEmitRd;
            end
          end
        end
        StEmitVl: begin
          if (accept && !vl_end) begin
            byte_cnt_q <= byte_cnt_q + 4'd1;
            out_data   <= vl_next_byte;
          end
        end
        StEmitRd: begin
          if (accept && rd_has_next) begin
            byte_cnt_q <= {2'b00, rd_next_lane};
            out_data   <= rd_next_byte;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (rd_load && (rd_wstrb != 4'b0000)) begin
        out_valid  <= 1'b1;
        out_data   <= rd_first_byte;
        byte_cnt_q <= {2'b00, rd_first_lane};
      end

      if (vl_end || rd_end) begin
        out_valid  <= 1'b0;
        byte_cnt_q <= '0;
        vl_pop     <= vl_end;
        rd_pop     <= rd_end;
      end

      if (field_end) begin
        next_idx_q <= next_idx_q + IDX_W'(1);
        if (last_field) begin
          done    <= 1'b1;
          state_q <= StIdle;
        end else begin
          state_q <= StPick;
        end
      end

      if (to_err) begin
        state_q    <= StErr;
        err        <= 1'b1;
        busy       <= 1'b0;
        out_valid  <= 1'b0;
        byte_cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_field_merge_sched.sv
// Bench for field_merge_sched: queue FIFO models feed the DUT, and the expected stream is the
// concatenation of each field's valid bytes in field-index order.
`timescale 1ns/1ps
module tb_field_merge_sched;

  localparam int unsigned IDX_W   = 10;
  localparam int unsigned TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] field_count = '0;
  logic             vl_empty = 1'b1;
  logic [79:0]      vl_data = '0;
  logic [3:0]       vl_size = '0;
  logic [IDX_W-1:0] vl_index = '0;
  logic             vl_pop;
  logic             rd_empty = 1'b1;
  logic [31:0]      rd_data = '0;
  logic [3:0]       rd_wstrb = '0;
  logic [IDX_W-1:0] rd_index = '0;
  logic             rd_last = 1'b0;
  logic             rd_pop;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;
  logic             done;
  logic             err;

  always #5 clk = ~clk;

  field_merge_sched #(.IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .field_count(field_count),
    .vl_empty(vl_empty), .vl_data(vl_data), .vl_size(vl_size), .vl_index(vl_index),
    .vl_pop(vl_pop), .rd_empty(rd_empty), .rd_data(rd_data), .rd_wstrb(rd_wstrb),
    .rd_index(rd_index), .rd_last(rd_last), .rd_pop(rd_pop), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // FIFO contents and reference stream
  logic [79:0]      vq_data[$];
  logic [3:0]       vq_size[$];
  logic [IDX_W-1:0] vq_idx[$];
  logic [31:0]      rq_data[$];
  logic [3:0]       rq_strb[$];
  logic [IDX_W-1:0] rq_idx[$];
  logic             rq_last[$];
  logic [7:0]       exp_q[$];
  logic [7:0]       got_q[$];
  int vl_pops = 0, rd_pops = 0, exp_vl_pops = 0, exp_rd_pops = 0, done_cnt = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: toggle

  initial begin : env
    logic pv, pr, tog, prev_stall;
    logic [7:0] prev_data;
    tog = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      pv = vl_pop;
      pr = rd_pop;
      if (reset && prev_stall) check("hold", {out_valid, out_data}, {1'b1, prev_data});
      prev_stall = reset && out_valid && !out_ready;
      prev_data = out_data;
      if (reset && out_valid && out_ready) got_q.push_back(out_data);
      if (reset && done) done_cnt++;
      @(posedge clk);
      #1;
      if (reset && pv) begin
        vl_pops++;
        if (vq_size.size() > 0) begin
          void'(vq_data.pop_front()); void'(vq_size.pop_front()); void'(vq_idx.pop_front());
        end
      end
      if (reset && pr) begin
        rd_pops++;
        if (rq_strb.size() > 0) begin
          void'(rq_data.pop_front()); void'(rq_strb.pop_front());
          void'(rq_idx.pop_front()); void'(rq_last.pop_front());
        end
      end
      vl_empty = (vq_size.size() == 0);
      vl_data  = vl_empty ? '0 : vq_data[0];
      vl_size  = vl_empty ? '0 : vq_size[0];
      vl_index = vl_empty ? '0 : vq_idx[0];
      rd_empty = (rq_strb.size() == 0);
      rd_data  = rd_empty ? '0 : rq_data[0];
      rd_wstrb = rd_empty ? '0 : rq_strb[0];
      rd_index = rd_empty ? '0 : rq_idx[0];
      rd_last  = rd_empty ? 1'b0 : rq_last[0];
      tog = ~tog;
      out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? ($urandom % 4 != 0) : tog;
    end
  end

  task automatic new_msg();
    exp_q.delete(); got_q.delete();
    vl_pops = 0; rd_pops = 0; exp_vl_pops = 0; exp_rd_pops = 0;
  endtask

  task automatic clear_fifos();
    vq_data.delete(); vq_size.delete(); vq_idx.delete();
    rq_data.delete(); rq_strb.delete(); rq_idx.delete(); rq_last.delete();
  endtask

  task automatic add_varint(input int idx, input int size, input logic [79:0] data);
    vq_data.push_back(data); vq_size.push_back(4'(size)); vq_idx.push_back(IDX_W'(idx));
    for (int b = 0; b < size; b++) exp_q.push_back(data[8*b +: 8]);
    exp_vl_pops++;
  endtask

  task automatic add_raw(input int idx, input logic [31:0] data, input logic [3:0] strb,
                         input logic last);
    rq_data.push_back(data); rq_strb.push_back(strb);
    rq_idx.push_back(IDX_W'(idx)); rq_last.push_back(last);
    for (int l = 0; l < 4; l++) if (strb[l]) exp_q.push_back(data[8*l +: 8]);
    exp_rd_pops++;
  endtask

  task automatic pulse_start(input int count);
    @(posedge clk); #2;
    start = 1'b1;
    field_count = IDX_W'(count);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic run_msg(input int count, input string tag);
    int d0, cyc;
    d0 = done_cnt;
    pulse_start(count);
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s done", tag), 80'(done_cnt - d0), 80'd1);
    repeat (4) @(negedge clk);
    check($sformatf("%s nbytes", tag), 80'(got_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s byte%0d", tag, i), (i < got_q.size()) ? 80'(got_q[i]) : 80'hbad,
            80'(exp_q[i]));
    check($sformatf("%s vl_pops", tag), 80'(vl_pops), 80'(exp_vl_pops));
    check($sformatf("%s rd_pops", tag), 80'(rd_pops), 80'(exp_rd_pops));
    check($sformatf("%s idle", tag), {busy, err, out_valid}, 3'b000);
    check($sformatf("%s drained", tag), 80'(vq_size.size() + rq_strb.size()), 80'd0);
  endtask

  initial begin : main
    int n, nw, cyc, d0;
    logic [79:0] d;
    #1;
    check("reset outputs", {out_valid, out_data, vl_pop, rd_pop, busy, done, err}, '0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Empty message: done pulse from IDLE
    new_msg();
    d0 = done_cnt;
    pulse_start(0);
    repeat (2) @(negedge clk);
    check("zero count done", 80'(done_cnt - d0), 80'd1);
    check("zero count busy", {busy, err}, 2'b00);

    new_msg();
    add_varint(0, 2, 80'h02AC);
    add_raw(1, 32'h44332211, 4'b1111, 1'b1);
    add_varint(2, 1, 80'h05);
    check("mixed ref", {exp_q[0], exp_q[1], exp_q[2], exp_q[5], exp_q[6]}, 40'hAC02114405);
    run_msg(3, "mixed");

    new_msg();
    add_raw(0, 32'hDDCCBBAA, 4'b0101, 1'b0);
    add_raw(0, 32'h00000099, 4'b0001, 1'b1);
    run_msg(1, "sparse");

    new_msg();
    add_raw(0, 32'h12345678, 4'b0000, 1'b0);
    add_raw(0, 32'h9ABCDEF0, 4'b1000, 1'b1);
    add_varint(1, 3, 80'hFFFF_FFFF_FFFF_FF33_2211);
    run_msg(2, "zero strb");

    new_msg();
    ready_mode = 2;
    add_varint(0, 10, 80'h0A09_0807_0605_0403_0201);
    run_msg(1, "backpressure");
    ready_mode = 0;

    // Ordering error: neither head matches next_idx 0
    new_msg();
    add_varint(3, 1, 80'h11);
    add_raw(5, 32'h22, 4'b0001, 1'b1);
    pulse_start(6);
    repeat (2) @(negedge clk);
    check("order err", {err, out_valid}, 2'b10);
    repeat (4) @(negedge clk);
    check("order no pop", 80'(vl_pops + rd_pops), 80'd0);
    check("order sticky", err, 1'b1);
    clear_fifos();
    pulse_start(0);
    repeat (2) @(negedge clk);
    check("order cleared", err, 1'b0);

    // Asynchronous reset in the middle of a raw word
    new_msg();
    add_raw(0, 32'h87654321, 4'b1111, 1'b1);
    pulse_start(1);
    cyc = 0;
    while (got_q.size() < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("reset mid bytes", 80'(got_q.size() >= 2), 80'd1);
    #1 reset = 1'b0;
    #1 check("reset mid outputs", {out_valid, out_data, vl_pop, rd_pop, busy, done, err}, '0);
    repeat (3) @(negedge clk);
    check("reset mid no pop", 80'(rd_pops), 80'd0);
    clear_fifos();
    @(posedge clk); #2 reset = 1'b1;

    // Both FIFOs empty: watchdog or indefinite wait
    new_msg();
    pulse_start(1);
`ifdef FIELD_MERGE_SCHED_WATCHDOG_EN
    repeat (8) @(negedge clk);
    check("wd early", err, 1'b0);
    repeat (14) @(negedge clk);
    check("wd fired", err, 1'b1);
`else
    repeat (1000) @(negedge clk);
    check("no wd err", {err, busy}, 2'b01);
`endif
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;

    for (int m = 0; m < 25; m++) begin
      new_msg();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if ($urandom % 2 == 0) begin
          d = {16'($urandom), 32'($urandom), 32'($urandom)};
          add_varint(i, $urandom_range(1, 10), d);
        end else begin
          nw = $urandom_range(1, 3);
          for (int w = 0; w < nw; w++) add_raw(i, 32'($urandom), 4'($urandom), w == nw - 1);
        end
      end
      ready_mode = $urandom_range(0, 1);
      run_msg(n, $sformatf("rand%0d", m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : guard
    #400000;
    $display("FAIL global timeout: got no finish, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
